id_stage: RTL and testbench

//  Instruction-decode stage, directly downstream of IF_Stage. Latches {PC, Instruction} into an IF/ID register.

---
 rtl/id_stage_pkg.sv | 69 ++++++
 rtl/id_stage_if.sv | 28 ++
 rtl/id_stage_reg_file.sv | 40 ++++
 rtl/id_stage.sv | 171 +++++++++++++++++
 tb/tb_id_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants and inter-stage bundles for the
// instruction-decode stage.
package id_stage_pkg;

  localparam int XLEN    = 32;
  localparam int NREG_AW = 5;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_NOR  = 6'h07;
  localparam logic [5:0] OP_XOR  = 6'h08;
  localparam logic [5:0] OP_SLA  = 6'h09;
  localparam logic [5:0] OP_SLL  = 6'h0A;
  localparam logic [5:0] OP_SRA  = 6'h0B;
  localparam logic [5:0] OP_SRL  = 6'h0C;
  localparam logic [5:0] OP_ADDI = 6'h20;
  localparam logic [5:0] OP_SUBI = 6'h21;
  localparam logic [5:0] OP_LD   = 6'h24;
  localparam logic [5:0] OP_ST   = 6'h25;
  localparam logic [5:0] OP_BEZ  = 6'h28;
  localparam logic [5:0] OP_BNE  = 6'h29;
  localparam logic [5:0] OP_JMP  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_NOR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SLA = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_SRL = 4'd10
  } alu_cmd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [3:0]         alu_cmd;
    logic [XLEN-1:0]    val1;
    logic [XLEN-1:0]    val2;
    logic [XLEN-1:0]    st_val;
    logic [NREG_AW-1:0] dest;
    logic               wb_en;
    logic               mem_rd;
    logic               mem_wr;
    logic [31:0]        pc;
  } id_ex_t;

endpackage

// File: rtl/id_stage_if.sv
// IF <-> ID bus: fetched {pc, instr} forward,
// stall and branch redirect back to fetch.
interface id_stage_if;
  import id_stage_pkg::*;

  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_address;

  modport master (
    output if_pc,
    output if_instr,
    input  stall,
    input  branch_taken,
    input  branch_address
  );

  modport slave (
    input  if_pc,
    input  if_instr,
    output stall,
    output branch_taken,
    output branch_address
  );

endinterface

// File: rtl/id_stage_reg_file.sv
// 2R/1W register file, r0 hardwired to zero,
// same-cycle write visible on the read ports.
module id_stage_reg_file
  import id_stage_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_AW = NREG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we
);

  logic [DATA_W-1:0] regs [2**REG_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++)
        regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, register read, RAW stall,
// branch resolve and the ID/EX register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_AW = NREG_AW
) (
  input  logic              clk,
  input  logic              rst,
  id_stage_if.slave         ifid,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_en,
  output logic [3:0]        ex_alu_cmd,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_st_val,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_wb_en,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [31:0]       ex_pc
);

  if_id_t ifid_q;
  id_ex_t idex_q;
  id_ex_t idex_d;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext;
  logic [31:0]       pc4;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  alu_cmd_t cmd;
  logic r_type, imm_alu, is_ld, is_st;
  logic is_bez, is_bne, is_jmp;
  logic use_rs, use_rt;
  logic hz_rs, hz_rt;
  logic stall, cond, taken;

  assign op   = ifid_q.instr[OP_HI:OP_LO];
  assign rs   = ifid_q.instr[RS_HI:RS_LO];
  assign rt   = ifid_q.instr[RT_HI:RT_LO];
  assign rd   = ifid_q.instr[RD_HI:RD_LO];
  assign imm  = ifid_q.instr[IMM_HI:IMM_LO];
  assign sext = {{(DATA_W-16){imm[15]}}, imm};
  assign pc4  = ifid_q.pc + 32'd4;

  id_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .wa  (wb_dest),
    .wd  (wb_data),
    .we  (wb_en)
  );

  always_comb begin
    cmd     = ALU_NOP;
    r_type  = 1'b0;
    imm_alu = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_bez  = 1'b0;
    is_bne  = 1'b0;
    is_jmp  = 1'b0;
    case (op)
      OP_ADD:  begin cmd = ALU_ADD; r_type = 1'b1; end
      OP_SUB:  begin cmd = ALU_SUB; r_type = 1'b1; end
      OP_AND:  begin cmd = ALU_AND; r_type = 1'b1; end
      OP_OR:   begin cmd = ALU_OR;  r_type = 1'b1; end
      OP_NOR:  begin cmd = ALU_NOR; r_type = 1'b1; end
      OP_XOR:  begin cmd = ALU_XOR; r_type = 1'b1; end
      OP_SLA:  begin cmd = ALU_SLA; r_type = 1'b1; end
      OP_SLL:  begin cmd = ALU_SLL; r_type = 1'b1; end
      OP_SRA:  begin cmd = ALU_SRA; r_type = 1'b1; end
      OP_SRL:  begin cmd = ALU_SRL; r_type = 1'b1; end
      OP_ADDI: begin cmd = ALU_ADD; imm_alu = 1'b1; end
      OP_SUBI: begin cmd = ALU_SUB; imm_alu = 1'b1; end
      OP_LD:   begin cmd = ALU_ADD; is_ld = 1'b1; end
      OP_ST:   begin cmd = ALU_ADD; is_st = 1'b1; end
      OP_BEZ:  is_bez = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      default: ;
    endcase
  end

  assign use_rs = r_type | imm_alu | is_ld
                | is_st | is_bez | is_bne;
  assign use_rt = r_type | is_st | is_bne;

  // No forwarding: any in-flight writer of a source must drain first.
  assign hz_rs = use_rs && rs != '0
              && ((idex_q.wb_en && rs == idex_q.dest)
               || (mem_wb_en && rs == mem_dest));
  assign hz_rt = use_rt && rt != '0
              && ((idex_q.wb_en && rt == idex_q.dest)
               || (mem_wb_en && rt == mem_dest));
  assign stall = hz_rs | hz_rt;

  assign cond  = is_jmp
               | (is_bez & (rd1 == '0))
               | (is_bne & (rd1 != rd2));
  assign taken = cond & ~stall;

  assign ifid.stall          = stall;
  assign ifid.branch_taken   = taken;
  assign ifid.branch_address = pc4 + {sext[29:0], 2'b00};

  always_comb begin
    idex_d         = '0;
    idex_d.alu_cmd = cmd;
    idex_d.val1    = rd1;
    idex_d.st_val  = rd2;
    idex_d.mem_rd  = is_ld;
    idex_d.mem_wr  = is_st;
    idex_d.pc      = pc4;
    unique case (1'b1)
      r_type:                  idex_d.val2 = rd2;
      imm_alu | is_ld | is_st: idex_d.val2 = sext;
      default:                 idex_d.val2 = '0;
    endcase
    unique case (1'b1)
      r_type:          idex_d.dest = rd;
      imm_alu | is_ld: idex_d.dest = rt;
      default:         idex_d.dest = '0;
    endcase
    idex_d.wb_en = (r_type | imm_alu | is_ld)
                && idex_d.dest != '0;
  end

  always_ff @(posedge clk) begin
    if (rst || taken)
      ifid_q <= '0;
    else if (!stall)
      ifid_q <= '{pc: ifid.if_pc, instr: ifid.if_instr};
  end

  always_ff @(posedge clk) begin
    if (rst || stall)
      idex_q <= '0;
    else
      idex_q <= idex_d;
  end

  assign ex_alu_cmd = idex_q.alu_cmd;
  assign ex_val1    = idex_q.val1;
  assign ex_val2    = idex_q.val2;
  assign ex_st_val  = idex_q.st_val;
  assign ex_dest    = idex_q.dest;
  assign ex_wb_en   = idex_q.wb_en;
  assign ex_mem_rd  = idex_q.mem_rd;
  assign ex_mem_wr  = idex_q.mem_wr;
  assign ex_pc      = idex_q.pc;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, RAW stall, branches,
// r0 handling and mid-stall reset.
module tb_id_stage;

  localparam logic [31:0] I_ADDI  = 32'h8001060A;
  localparam logic [31:0] I_ADD2  = 32'h04011000;
  localparam logic [31:0] I_BNE   = 32'hA423FFF1;
  localparam logic [31:0] I_JMP   = 32'hA800FFFF;
  localparam logic [31:0] I_XOR   = 32'h20A10000;
  localparam logic [31:0] I_ADD6  = 32'h04003000;
  localparam logic [31:0] I_ADD7  = 32'h04C03800;
  localparam logic [31:0] I_ADD13 = 32'h04231000;
  localparam logic [31:0] I_LD    = 32'h90040008;
  localparam logic [31:0] I_ST    = 32'h9404FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_dest;
  logic        mem_wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [3:0]  ex_alu_cmd;
  logic [31:0] ex_val1;
  logic [31:0] ex_val2;
  logic [31:0] ex_st_val;
  logic [4:0]  ex_dest;
  logic        ex_wb_en;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_pc;

  int total = 0;
  int bad   = 0;

  id_stage_if ifb ();

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ifid       (ifb),
    .mem_dest   (mem_dest),
    .mem_wb_en  (mem_wb_en),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .wb_en      (wb_en),
    .ex_alu_cmd (ex_alu_cmd),
    .ex_val1    (ex_val1),
    .ex_val2    (ex_val2),
    .ex_st_val  (ex_st_val),
    .ex_dest    (ex_dest),
    .ex_wb_en   (ex_wb_en),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_pc      (ex_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] instr);
    ifb.if_pc    = pc;
    ifb.if_instr = instr;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_dest = '0; mem_wb_en = 1'b0;
    wb_dest = '0; wb_data = '0; wb_en = 1'b0;
    fetch(32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cmd",   ex_alu_cmd, 0);
    chk("rst_wb",    ex_wb_en, 0);
    chk("rst_pc",    ex_pc, 0);
    chk("rst_stall", ifb.stall, 0);
    chk("rst_br",    ifb.branch_taken, 0);

    // ADDI r1,r0,1546 then dependent ADD r2,r0,r1
    fetch(32'd4, I_ADDI);
    tick();
    fetch(32'd8, I_ADD2);
    #1;
    chk("addi_nostall", ifb.stall, 0);
    tick();
    chk("addi_cmd",  ex_alu_cmd, 1);
    chk("addi_v1",   ex_val1, 0);
    chk("addi_v2",   ex_val2, 1546);
    chk("addi_dest", ex_dest, 1);
    chk("addi_wb",   ex_wb_en, 1);
    chk("addi_pc",   ex_pc, 8);
    fetch(32'd12, 32'd0);
    #1;
    chk("raw_ex_stall", ifb.stall, 1);
    tick();
    mem_dest = 5'd1; mem_wb_en = 1'b1;
    #1;
    chk("bubble1_cmd", ex_alu_cmd, 0);
    chk("bubble1_wb",  ex_wb_en, 0);
    chk("raw_mem_stall", ifb.stall, 1);
    tick();
    mem_dest = '0; mem_wb_en = 1'b0;
    wb_en = 1'b1; wb_dest = 5'd1; wb_data = 32'd1546;
    #1;
    chk("raw_clear", ifb.stall, 0);
    chk("bubble2_dest", ex_dest, 0);
    tick();
    chk("add_cmd",  ex_alu_cmd, 1);
    chk("add_wt",   ex_val2, 1546);
    chk("add_dest", ex_dest, 2);
    chk("add_pc",   ex_pc, 12);

    // BNE r1,r3,-15: r1=3, r3=1 -> taken
    wb_dest = 5'd1; wb_data = 32'd3;
    fetch(32'd16, 32'd0);
    tick();
    wb_dest = 5'd3; wb_data = 32'd1;
    fetch(32'd192, I_BNE);
    tick();
    wb_en = 1'b0;
    fetch(32'd196, I_ADD2);
    #1;
    chk("bne_taken", ifb.branch_taken, 1);
    chk("bne_addr",  ifb.branch_address, 136);
    chk("bne_stall", ifb.stall, 0);
    tick();
    fetch(32'd200, 32'd0);
    #1;
    chk("bne_ex_pc",  ex_pc, 196);
    chk("bne_ex_cmd", ex_alu_cmd, 0);
    chk("bne_ex_wb",  ex_wb_en, 0);
    chk("bne_bubble", ifb.branch_taken, 0);
    tick();
    chk("kill_pc",  ex_pc, 4);
    chk("kill_cmd", ex_alu_cmd, 0);

    // r3=3 -> not taken; hazard holds a taken branch
    wb_en = 1'b1; wb_dest = 5'd3; wb_data = 32'd3;
    fetch(32'd192, I_BNE);
    tick();
    wb_en = 1'b0;
    fetch(32'd256, I_JMP);
    #1;
    chk("bne_equal", ifb.branch_taken, 0);
    wb_en = 1'b1; wb_dest = 5'd3; wb_data = 32'd1;
    #1;
    chk("bne_wt_taken", ifb.branch_taken, 1);
    mem_dest = 5'd3; mem_wb_en = 1'b1;
    #1;
    chk("bne_hz_stall", ifb.stall, 1);
    chk("bne_hz_hold",  ifb.branch_taken, 0);
    mem_dest = '0; mem_wb_en = 1'b0; wb_en = 1'b0;
    tick();

    // JMP -1 at pc=256 loops on itself
    #1;
    chk("jmp1_taken", ifb.branch_taken, 1);
    chk("jmp1_addr",  ifb.branch_address, 256);
    tick();
    #1;
    chk("jmp_bubble", ifb.branch_taken, 0);
    tick();
    #1;
    chk("jmp2_taken", ifb.branch_taken, 1);
    chk("jmp2_addr",  ifb.branch_address, 256);
    tick();

    // XOR r0,r5,r1 and ADD r6,r0,r0
    fetch(32'd300, I_XOR);
    tick();
    #1;
    chk("xor_nostall", ifb.stall, 0);
    fetch(32'd304, I_ADD6);
    tick();
    chk("xor_cmd", ex_alu_cmd, 6);
    chk("xor_wb",  ex_wb_en, 0);
    chk("xor_v2",  ex_val2, 3);
    mem_dest = 5'd0; mem_wb_en = 1'b1;
    wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'hDEAD_BEEF;
    fetch(32'd308, 32'd0);
    #1;
    chk("r0_nostall", ifb.stall, 0);
    tick();
    mem_wb_en = 1'b0; wb_en = 1'b0;
    chk("add6_dest", ex_dest, 6);
    chk("r0_read",   ex_val1, 0);
    chk("add6_wb",   ex_wb_en, 1);

    // reset in the middle of a stall
    fetch(32'd312, I_ADD7);
    tick();
    mem_dest = 5'd6; mem_wb_en = 1'b1;
    #1;
    chk("pre_rst_stall", ifb.stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0;
    #1;
    chk("mrst_cmd",   ex_alu_cmd, 0);
    chk("mrst_wb",    ex_wb_en, 0);
    chk("mrst_dest",  ex_dest, 0);
    chk("mrst_v1",    ex_val1, 0);
    chk("mrst_pc",    ex_pc, 0);
    chk("mrst_stall", ifb.stall, 0);
    chk("mrst_br",    ifb.branch_taken, 0);
    fetch(32'd400, I_ADD13);
    tick();
    fetch(32'd404, I_LD);
    tick();
    chk("rst_r1", ex_val1, 0);
    chk("rst_r3", ex_val2, 0);
    chk("rst_st", ex_st_val, 0);
    chk("rst_add_pc", ex_pc, 404);

    // LD r4,8(r0) then ST r4 -> load-use stall
    fetch(32'd408, I_ST);
    tick();
    chk("ld_rd",   ex_mem_rd, 1);
    chk("ld_cmd",  ex_alu_cmd, 1);
    chk("ld_v2",   ex_val2, 8);
    chk("ld_dest", ex_dest, 4);
    chk("ld_wb",   ex_wb_en, 1);
    fetch(32'd412, 32'd0);
    #1;
    chk("load_use", ifb.stall, 1);
    tick();
    #1;
    chk("load_use_clear", ifb.stall, 0);
    tick();
    chk("st_wr",  ex_mem_wr, 1);
    chk("st_rd",  ex_mem_rd, 0);
    chk("st_wb",  ex_wb_en, 0);
    chk("st_cmd", ex_alu_cmd, 1);
    chk("st_v2",  ex_val2, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
